// File: rtl/blood_abnormality_monitor.sv
// Multi-channel blood pH abnormality monitor: per-channel classification, persistence-filtered
// alarm, sticky alarm latch with acknowledge, and a saturating alarm-event counter.
module blood_abnormality_monitor #(
    parameter int         NUM_CH     = 2,
    parameter logic [7:0] CLASS_MASK = 8'b1010_1010,
    parameter int         P_LOW      = 7,
    parameter int         P_HIGH     = 11,
    parameter int         Q_LOW      = 5,
    parameter int         Q_HIGH     = 9,
    parameter int         PERSIST    = 3,
    parameter int         CLEAR      = 2,
    parameter int         CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    rstN,
    input  logic [NUM_CH-1:0]       sampleValid,
    input  logic [4*NUM_CH-1:0]     bloodPH,
    input  logic [3*NUM_CH-1:0]     bloodType,
    input  logic [NUM_CH-1:0]       alarmAck,
    output logic [NUM_CH-1:0]       bloodAbnormality,
    output logic [NUM_CH-1:0]       alarm,
    output logic [NUM_CH-1:0]       alarmLatched,
    output logic                    anyAlarm,
    output logic [CNT_W*NUM_CH-1:0] eventCount
);

    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_SUSPECT,
        ST_ALARM,
        ST_RECOVER
    } state_t;

    localparam logic [3:0] P_LO_C    = 4'(P_LOW);
    localparam logic [3:0] P_HI_C    = 4'(P_HIGH);
    localparam logic [3:0] Q_LO_C    = 4'(Q_LOW);
    localparam logic [3:0] Q_HI_C    = 4'(Q_HIGH);
    localparam logic [3:0] PERSIST_C = 4'(PERSIST);
    localparam logic [3:0] CLEAR_C   = 4'(CLEAR);

    state_t                    state_q [NUM_CH];
    state_t                    state_d [NUM_CH];
    logic   [3:0]              run_q   [NUM_CH];
    logic   [3:0]              run_d   [NUM_CH];
    logic   [NUM_CH-1:0]       abn;
    logic   [NUM_CH-1:0]       abn_q, abn_d;
    logic   [NUM_CH-1:0]       alarm_q, alarm_d;
    logic   [NUM_CH-1:0]       latched_q, latched_d;
    logic   [NUM_CH-1:0]       rise;
    logic                      any_q;
    logic   [CNT_W*NUM_CH-1:0] cnt_q, cnt_d;

    function automatic logic classify(input logic [3:0] ph, input logic [2:0] bt);
        if (CLASS_MASK[bt]) return (ph < Q_LO_C) || (ph > Q_HI_C);
        return (ph < P_LO_C) || (ph > P_HI_C);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_comb begin
        abn       = '0;
        abn_d     = abn_q;
        alarm_d   = '0;
        latched_d = '0;
        rise      = '0;
        cnt_d     = cnt_q;
        for (int c = 0; c < NUM_CH; c++) begin
            abn[c]     = classify(bloodPH[4*c +: 4], bloodType[3*c +: 3]);
            state_d[c] = state_q[c];
            run_d[c]   = run_q[c];
            if (sampleValid[c]) begin
                abn_d[c] = abn[c];
                unique case (state_q[c])
                    ST_NORMAL: begin
                        if (abn[c]) begin
                            run_d[c]   = 4'd1;
                            state_d[c] = (PERSIST == 1) ? ST_ALARM : ST_SUSPECT;
                        end else begin
                            run_d[c] = 4'd0;
                        end
                    end
                    ST_SUSPECT: begin
                        if (!abn[c]) begin
                            state_d[c] = ST_NORMAL;
                            run_d[c]   = 4'd0;
                        end else if (run_q[c] + 4'd1 == PERSIST_C) begin
                            state_d[c] = ST_ALARM;
                            run_d[c]   = 4'd0;
                        end else begin
                            run_d[c] = run_q[c] + 4'd1;
                        end
                    end
                    ST_ALARM: begin
                        if (!abn[c]) begin
                            run_d[c]   = 4'd1;
                            state_d[c] = (CLEAR == 1) ? ST_NORMAL : ST_RECOVER;
                        end else begin
                            run_d[c] = 4'd0;
                        end
                    end
                    default: begin
                        if (abn[c]) begin
                            state_d[c] = ST_ALARM;
                            run_d[c]   = 4'd0;
                        end else if (run_q[c] + 4'd1 == CLEAR_C) begin
                            state_d[c] = ST_NORMAL;
                            run_d[c]   = 4'd0;
                        end else begin
                            run_d[c] = run_q[c] + 4'd1;
                        end
                    end
                endcase
            end
            alarm_d[c] = (state_d[c] == ST_ALARM) || (state_d[c] == ST_RECOVER);
            // A new rising edge wins over a simultaneous acknowledge.
            rise[c]      = alarm_d[c] & ~alarm_q[c];
            latched_d[c] = rise[c] | (latched_q[c] & ~alarmAck[c]);
            if (rise[c]) cnt_d[CNT_W*c +: CNT_W] = sat_inc(cnt_q[CNT_W*c +: CNT_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= ST_NORMAL;
                run_q[c]   <= 4'd0;
            end
            abn_q     <= '0;
            alarm_q   <= '0;
            latched_q <= '0;
            any_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                run_q[c]   <= run_d[c];
            end
            abn_q     <= abn_d;
            alarm_q   <= alarm_d;
            latched_q <= latched_d;
            any_q     <= |alarm_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bloodAbnormality = abn_q;
    assign alarm            = alarm_q;
    assign alarmLatched     = latched_q;
    assign anyAlarm         = any_q;
    assign eventCount       = cnt_q;

endmodule

// File: tb/tb_blood_abnormality_monitor.sv
// Randomized and directed bench for blood_abnormality_monitor against a streak-counting
// reference model; a narrow counter width makes saturation reachable.
module tb_blood_abnormality_monitor;

    localparam int         NUM_CH  = 2;
    localparam int         CNT_W   = 2;
    localparam int         PERSIST = 3;
    localparam int         CLEAR   = 2;
    localparam logic [7:0] MASK    = 8'b1010_1010;
    localparam int         CNT_MAX = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    rstN;
    logic [NUM_CH-1:0]       sampleValid;
    logic [4*NUM_CH-1:0]     bloodPH;
    logic [3*NUM_CH-1:0]     bloodType;
    logic [NUM_CH-1:0]       alarmAck;
    logic [NUM_CH-1:0]       bloodAbnormality;
    logic [NUM_CH-1:0]       alarm;
    logic [NUM_CH-1:0]       alarmLatched;
    logic                    anyAlarm;
    logic [CNT_W*NUM_CH-1:0] eventCount;

    int n_vec  = 0;
    int n_fail = 0;

    int m_abn     [NUM_CH];
    int m_alarm   [NUM_CH];
    int m_astreak [NUM_CH];
    int m_nstreak [NUM_CH];
    int m_latched [NUM_CH];
    int m_count   [NUM_CH];
    int m_any;

    blood_abnormality_monitor #(
        .NUM_CH (NUM_CH), .CLASS_MASK(MASK), .P_LOW(7), .P_HIGH(11), .Q_LOW(5), .Q_HIGH(9),
        .PERSIST(PERSIST), .CLEAR(CLEAR), .CNT_W(CNT_W)
    ) dut (
        .clk             (clk),
        .rstN            (rstN),
        .sampleValid     (sampleValid),
        .bloodPH         (bloodPH),
        .bloodType       (bloodType),
        .alarmAck        (alarmAck),
        .bloodAbnormality(bloodAbnormality),
        .alarm           (alarm),
        .alarmLatched    (alarmLatched),
        .anyAlarm        (anyAlarm),
        .eventCount      (eventCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int ref_abn(input logic [3:0] ph, input logic [2:0] ty);
        int lo, hi;
        logic [7:0] mask;
        mask = MASK;
        lo = mask[ty] ? 5 : 7;
        hi = mask[ty] ? 9 : 11;
        return (int'(ph) < lo || int'(ph) > hi) ? 1 : 0;
    endfunction

    // Model: an alarm is a run of PERSIST abnormal samples, released by a run of CLEAR normal ones.
    task automatic model_update();
        int prev, a;
        if (!rstN) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_abn[c] = 0; m_alarm[c] = 0; m_astreak[c] = 0;
                m_nstreak[c] = 0; m_latched[c] = 0; m_count[c] = 0;
            end
            m_any = 0;
            return;
        end
        m_any = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            prev = m_alarm[c];
            if (sampleValid[c]) begin
                a = ref_abn(bloodPH[4*c +: 4], bloodType[3*c +: 3]);
                m_abn[c] = a;
                if (m_alarm[c] == 0) begin
                    m_astreak[c] = a ? m_astreak[c] + 1 : 0;
                    if (m_astreak[c] >= PERSIST) begin
                        m_alarm[c] = 1; m_astreak[c] = 0; m_nstreak[c] = 0;
                    end
                end else begin
                    m_nstreak[c] = a ? 0 : m_nstreak[c] + 1;
                    if (m_nstreak[c] >= CLEAR) begin
                        m_alarm[c] = 0; m_nstreak[c] = 0; m_astreak[c] = 0;
                    end
                end
            end
            if (m_alarm[c] == 1 && prev == 0) begin
                m_latched[c] = 1;
                m_count[c]   = (m_count[c] < CNT_MAX) ? m_count[c] + 1 : CNT_MAX;
            end else if (alarmAck[c]) begin
                m_latched[c] = 0;
            end
            if (m_alarm[c] != 0) m_any = 1;
        end
    endtask

    task automatic compare_all();
        logic [NUM_CH-1:0]       e_abn, e_alarm, e_lat;
        logic [CNT_W*NUM_CH-1:0] e_cnt;
        for (int c = 0; c < NUM_CH; c++) begin
            e_abn[c]   = (m_abn[c] != 0);
            e_alarm[c] = (m_alarm[c] != 0);
            e_lat[c]   = (m_latched[c] != 0);
            e_cnt[CNT_W*c +: CNT_W] = CNT_W'(m_count[c]);
        end
        check("bloodAbnormality", 32'(bloodAbnormality), 32'(e_abn));
        check("alarm", 32'(alarm), 32'(e_alarm));
        check("alarmLatched", 32'(alarmLatched), 32'(e_lat));
        check("anyAlarm", 32'(anyAlarm), 32'(m_any != 0));
        check("eventCount", 32'(eventCount), 32'(e_cnt));
    endtask

    task automatic step(input logic [NUM_CH-1:0] v, input logic [4*NUM_CH-1:0] ph,
                        input logic [3*NUM_CH-1:0] ty, input logic [NUM_CH-1:0] ack,
                        input logic rn);
        @(negedge clk);
        sampleValid = v; bloodPH = ph; bloodType = ty; alarmAck = ack; rstN = rn;
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    // Single-channel sample helpers; the other channel is idle.
    task automatic s0(input logic [3:0] ph, input logic ack);
        step(2'b01, {4'd0, ph}, {3'd0, 3'd0}, {1'b0, ack}, 1'b1);
    endtask

    task automatic s1(input logic [3:0] ph);
        step(2'b10, {ph, 4'd0}, {3'd1, 3'd0}, 2'b00, 1'b1);
    endtask

    initial begin
        logic [4*NUM_CH-1:0] ph;
        logic [3*NUM_CH-1:0] ty;
        logic [NUM_CH-1:0]   ack;
        logic                rn;

        sampleValid = '0; bloodPH = '0; bloodType = '0; alarmAck = '0; rstN = 1'b0;

        // Reset and idle
        step('0, '0, '0, '0, 1'b0);
        step('0, '0, '0, '0, 1'b0);
        step('0, '0, '0, '0, 1'b1);
        check("idle_alarm", 32'(alarm), 32'd0);
        check("idle_count", 32'(eventCount), 32'd0);

        // Class P persistence on ch0
        s0(4'd3, 1'b0);
        check("p_abn_first", 32'(bloodAbnormality[0]), 32'd1);
        check("p_no_alarm_1", 32'(alarm[0]), 32'd0);
        s0(4'd3, 1'b0);
        check("p_no_alarm_2", 32'(alarm[0]), 32'd0);
        s0(4'd3, 1'b0);
        check("p_alarm", 32'(alarm[0]), 32'd1);
        check("p_latched", 32'(alarmLatched[0]), 32'd1);
        check("p_count", 32'(eventCount[CNT_W-1:0]), 32'd1);
        check("p_any", 32'(anyAlarm), 32'd1);
        check("p_ch1_quiet", 32'(alarm[1]), 32'd0);

        // Recovery: normal, abn, normal, normal
        s0(4'd8, 1'b0);
        check("r_hold_1", 32'(alarm[0]), 32'd1);
        s0(4'd3, 1'b0);
        s0(4'd8, 1'b0);
        check("r_hold_2", 32'(alarm[0]), 32'd1);
        s0(4'd8, 1'b0);
        check("r_drop", 32'(alarm[0]), 32'd0);
        check("r_latch_held", 32'(alarmLatched[0]), 32'd1);
        s0(4'd8, 1'b1);
        check("r_ack", 32'(alarmLatched[0]), 32'd0);

        // Class Q window and filter reset on ch1
        s1(4'd10); s1(4'd10); s1(4'd9);
        check("q_normal", 32'(bloodAbnormality[1]), 32'd0);
        s1(4'd10); s1(4'd10);
        check("q_no_alarm", 32'(alarm[1]), 32'd0);
        s1(4'd10);
        check("q_alarm", 32'(alarm[1]), 32'd1);

        // Four more episodes on ch0 (five total): counter saturates; ack loses to a new rise
        for (int e = 0; e < 4; e++) begin
            s0(4'd3, 1'b0); s0(4'd3, 1'b0); s0(4'd3, 1'b1);
            check("sat_set_wins", 32'(alarmLatched[0]), 32'd1);
            s0(4'd8, 1'b0); s0(4'd8, 1'b0);
        end
        check("sat_count", 32'(eventCount[CNT_W-1:0]), 32'(CNT_MAX));

        // Reset mid-filter discards the partial run
        s0(4'd3, 1'b0); s0(4'd3, 1'b0);
        step('0, '0, '0, '0, 1'b0);
        s0(4'd3, 1'b0);
        check("rst_no_alarm", 32'(alarm[0]), 32'd0);
        s0(4'd3, 1'b0);
        s0(4'd3, 1'b0);
        check("rst_alarm_again", 32'(alarm[0]), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ph[4*c +: 4] = $urandom_range(0, 1) ? 4'($urandom_range(7, 9))
                                                    : 4'($urandom_range(0, 15));
                ty[3*c +: 3] = 3'($urandom_range(0, 7));
                ack[c]       = ($urandom_range(0, 7) == 0);
            end
            rn = ($urandom_range(0, 199) != 0);
            step(NUM_CH'($urandom), ph, ty, ack, rn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
